// File: rtl/bram_delay_prog_if.sv
// Purpose: sample/delay bundle between a datapath and a programmable BRAM delay line.
// Latency: n/a (signal bundle only).
// Backpressure: none; samples advance on ce, there is no ready path.
//   master: drives ce, din, delay_in, delay_ld; observes dout, dout_valid, delay_cur.
//   slave : the delay line itself.
interface bram_delay_prog_if #(
    parameter int WIDTH      = 32,
    parameter int DELAY_BITS = 11
);
    logic                  ce;
    logic [WIDTH-1:0]      din;
    logic [DELAY_BITS-1:0] delay_in;
    logic                  delay_ld;
    logic [WIDTH-1:0]      dout;
    logic                  dout_valid;
    logic [DELAY_BITS-1:0] delay_cur;

    modport master (
        output ce, din, delay_in, delay_ld,
        input  dout, dout_valid, delay_cur
    );

    modport slave (
        input  ce, din, delay_in, delay_ld,
        output dout, dout_valid, delay_cur
    );
endinterface

// File: rtl/bram_delay_prog.sv
// Purpose: run-time programmable sample delay line on an inferred simple-dual-port block RAM.
// Latency: dout after sample n is din of sample n-d, d = clamped delay (LATENCY..MAX_DELAY samples).
// Backpressure: none; every state element advances only on ce=1 and holds otherwise.
//   clk/rst : single clock, synchronous active-high reset.
//   bus     : slave side of bram_delay_prog_if (ce, din, delay_in, delay_ld -> dout, dout_valid, delay_cur).
module bram_delay_prog #(
    parameter int WIDTH         = 32,
    parameter int MAX_DELAY     = 1024,
    parameter int LATENCY       = 2,
    parameter int DEFAULT_DELAY = 1024,
    parameter int DELAY_BITS    = 11
) (
    input  logic              clk,
    input  logic              rst,
    bram_delay_prog_if.slave  bus
);
    localparam int ADDR_BITS = (MAX_DELAY <= 512) ? 9 : $clog2(MAX_DELAY);
    localparam int DEPTH     = 1 << ADDR_BITS;
    localparam int FC_BITS   = DELAY_BITS + 1;
    localparam int DEFAULT_CLAMPED = (DEFAULT_DELAY < LATENCY)   ? LATENCY   :
                                     (DEFAULT_DELAY > MAX_DELAY) ? MAX_DELAY : DEFAULT_DELAY;

    function automatic logic [DELAY_BITS-1:0] clamp_delay(input logic [DELAY_BITS-1:0] req);
        if (req < DELAY_BITS'(LATENCY))
            return DELAY_BITS'(LATENCY);
        else if (req > DELAY_BITS'(MAX_DELAY))
            return DELAY_BITS'(MAX_DELAY);
        else
            return req;
    endfunction

    logic [WIDTH-1:0]      ram [DEPTH];
    logic [ADDR_BITS-1:0]  wp;
    logic [ADDR_BITS-1:0]  ra;
    logic [WIDTH-1:0]      rd_q;
    logic [WIDTH-1:0]      pipe_out;
    logic [DELAY_BITS-1:0] delay_q;
    logic [FC_BITS-1:0]    fc;
    logic                  started;
    logic                  valid_q;

    // The sample read at this edge reaches dout LATENCY-1 samples later, so the
    // read address leads "wp - d" by LATENCY-1. At the minimum delay this puts
    // the read one slot behind the write. At d = DEPTH with LATENCY=1 the two
    // addresses coincide, and read-first returns the sample written DEPTH ago.
    assign ra = wp - ADDR_BITS'(delay_q) + ADDR_BITS'(LATENCY - 1);

    // Plain write port and read-first registered read: infers RAMB18/36.
    always_ff @(posedge clk) begin
        if (bus.ce)
            ram[wp] <= bus.din;
    end

    // RAM output latch; its sync reset and ce enable map onto the BRAM's own pins.
    always_ff @(posedge clk) begin
        if (rst)
            rd_q <= '0;
        else if (bus.ce)
            rd_q <= ram[ra];
    end

    generate
        if (LATENCY == 2) begin : g_oreg
            logic [WIDTH-1:0] out_q;
            always_ff @(posedge clk) begin
                if (rst)
                    out_q <= '0;
                else if (bus.ce)
                    out_q <= rd_q;
            end
            assign pipe_out = out_q;
        end else begin : g_noreg
            assign pipe_out = rd_q;
        end
    endgenerate

    // Fill tracking. The "reference" sample is the first one whose data is
    // genuine: the load edge itself, or the first sample after reset. fc counts
    // samples since the reference; dout carries genuine data once fc reaches d.
    // 'started' marks that the reference sample has been taken after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp      <= '0;
            delay_q <= DELAY_BITS'(DEFAULT_CLAMPED);
            fc      <= '0;
            started <= 1'b0;
            valid_q <= 1'b0;
        end else if (bus.ce) begin
            wp <= wp + 1'b1;
            if (bus.delay_ld) begin
                delay_q <= clamp_delay(bus.delay_in);
                fc      <= '0;
                started <= 1'b1;
                valid_q <= 1'b0;
            end else if (!started) begin
                started <= 1'b1;
            end else if (fc != FC_BITS'(delay_q)) begin
                fc <= fc + 1'b1;
                if (fc + 1'b1 == FC_BITS'(delay_q))
                    valid_q <= 1'b1;
            end
        end
    end

    // Stale RAM/pipeline contents are masked until the fill completes.
    assign bus.dout       = valid_q ? pipe_out : '0;
    assign bus.dout_valid = valid_q;
    assign bus.delay_cur  = delay_q;
endmodule
